// File: rtl/alu_result_seg.sv
// alu_result_seg: captures one ALU result and its flags through a valid/ready handshake
// and shows the held copy on a 4-digit multiplexed display. Optional flag digits: ALU_SEG_FLAGS_EN.
`default_nettype none

module alu_result_seg #(
  parameter logic [15:0] SCAN_DIV = 16'd50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_res,
  input  logic       in_zero,
  input  logic       in_overflow,
  input  logic       in_carry,
  input  logic       in_signed,
  input  logic       clear,
  output logic [7:0] seg_o,
  output logic [3:0] an_o,
  output logic [2:0] flags_o,
  output logic       shown_valid
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SHOW = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_div;
  logic [15:0] w_div_nxt;
  logic [1:0]  r_idx;
  logic [1:0]  w_idx_nxt;
  logic [3:0]  r_res;
  logic [3:0]  w_res_nxt;
  logic [2:0]  r_flags;
  logic [2:0]  w_flags_nxt;
  logic        r_signed;
  logic        w_signed_nxt;
  logic [7:0]  r_seg;
  logic [7:0]  w_seg_nxt;
  logic [3:0]  r_an;
  logic        w_accept;
  logic        w_wrap;
  logic        w_neg;
  logic [3:0]  w_mag;
  logic [7:0]  w_d2;
  logic [7:0]  w_d3;

  function automatic logic [7:0] f_glyph(input logic [3:0] v);
    case (v)
      4'h0: f_glyph = 8'hC0;
      4'h1: f_glyph = 8'hF9;
      4'h2: f_glyph = 8'hA4;
      4'h3: f_glyph = 8'hB0;
      4'h4: f_glyph = 8'h99;
      4'h5: f_glyph = 8'h92;
      4'h6: f_glyph = 8'h82;
      4'h7: f_glyph = 8'hF8;
      4'h8: f_glyph = 8'h80;
      4'h9: f_glyph = 8'h90;
      4'hA: f_glyph = 8'h88;
      4'hB: f_glyph = 8'h83;
      4'hC: f_glyph = 8'hC6;
      4'hD: f_glyph = 8'hA1;
      4'hE: f_glyph = 8'h86;
      default: f_glyph = 8'h8E;
    endcase
  endfunction

  assign in_ready    = (r_state != LOAD) & ~clear;
  assign w_accept    = in_valid & in_ready;
  assign shown_valid = (r_state != IDLE);
  assign seg_o       = r_seg;
  assign an_o        = r_an;
  assign flags_o     = r_flags;

  always_comb begin
    w_state_nxt = r_state;
    if (clear) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (w_accept) w_state_nxt = LOAD;
        LOAD:    w_state_nxt = SHOW;
        SHOW:    if (w_accept) w_state_nxt = LOAD;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    w_res_nxt    = r_res;
    w_flags_nxt  = r_flags;
    w_signed_nxt = r_signed;
    if (clear) begin
      w_res_nxt    = 4'd0;
      w_flags_nxt  = 3'd0;
      w_signed_nxt = 1'b0;
    end else if (w_accept) begin
      w_res_nxt    = in_res;
      w_flags_nxt  = {in_overflow, in_carry, in_zero};
      w_signed_nxt = in_signed;
    end
  end

  assign w_wrap    = (r_div == SCAN_DIV - 16'd1);
  assign w_div_nxt = w_wrap ? 16'd0 : r_div + 16'd1;
  assign w_idx_nxt = w_wrap ? r_idx + 2'd1 : r_idx;

  // Decode from next-cycle values so seg_o and an_o land together and a capture shows in LOAD.
  assign w_neg = w_signed_nxt & w_res_nxt[3];
  assign w_mag = w_neg ? (4'd0 - w_res_nxt) : w_res_nxt;

`ifdef ALU_SEG_FLAGS_EN
  always_comb begin
    w_d3    = w_flags_nxt[1] ? 8'hC6 : 8'hFF;
    w_d2    = w_flags_nxt[2] ? 8'hA3 : 8'hFF;
    w_d2[7] = ~w_flags_nxt[0];
  end
`else
  assign w_d3 = 8'hFF;
  assign w_d2 = 8'hFF;
`endif

  always_comb begin
    w_seg_nxt = 8'hFF;
    if (w_state_nxt != IDLE) begin
      case (w_idx_nxt)
        2'd0:    w_seg_nxt = f_glyph(w_mag);
        2'd1:    w_seg_nxt = w_neg ? 8'hBF : 8'hFF;
        2'd2:    w_seg_nxt = w_d2;
        default: w_seg_nxt = w_d3;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_div    <= 16'd0;
      r_idx    <= 2'd0;
      r_res    <= 4'd0;
      r_flags  <= 3'd0;
      r_signed <= 1'b0;
      r_seg    <= 8'hFF;
      r_an     <= 4'b1110;
    end else begin
      r_state  <= w_state_nxt;
      r_div    <= w_div_nxt;
      r_idx    <= w_idx_nxt;
      r_res    <= w_res_nxt;
      r_flags  <= w_flags_nxt;
      r_signed <= w_signed_nxt;
      r_seg    <= w_seg_nxt;
      r_an     <= ~(4'b0001 << w_idx_nxt);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_result_seg.sv
// tb_alu_result_seg: scoreboard bench for alu_result_seg with SCAN_DIV=4.
`default_nettype none

module tb_alu_result_seg;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_res = 4'd0;
  logic       in_zero = 1'b0;
  logic       in_overflow = 1'b0;
  logic       in_carry = 1'b0;
  logic       in_signed = 1'b0;
  logic       clear = 1'b0;
  logic [7:0] seg_o;
  logic [3:0] an_o;
  logic [2:0] flags_o;
  logic       shown_valid;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [31:0] segs;  // {d3,d2,d1,d0}
    logic [2:0]  flags;
  } exp_t;

  exp_t sb_q[$];

  alu_result_seg #(.SCAN_DIV(16'd4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_res(in_res), .in_zero(in_zero), .in_overflow(in_overflow),
    .in_carry(in_carry), .in_signed(in_signed), .clear(clear),
    .seg_o(seg_o), .an_o(an_o), .flags_o(flags_o), .shown_valid(shown_valid)
  );

  always #5 clk = ~clk;

  function automatic exp_t make_exp(input logic [7:0] d0, input logic [7:0] d1,
                                    input logic o, input logic c, input logic z);
    exp_t e;
    logic [7:0] d2;
    logic [7:0] d3;
`ifdef ALU_SEG_FLAGS_EN
    d3 = c ? 8'hC6 : 8'hFF;
    d2 = o ? 8'hA3 : 8'hFF;
    d2[7] = ~z;
`else
    d3 = 8'hFF;
    d2 = 8'hFF;
`endif
    e.segs  = {d3, d2, d1, d0};
    e.flags = {o, c, z};
    return e;
  endfunction

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (seg_o !== 8'hFF) begin bad++; $display("FAIL reset_seg got=%h want=ff", seg_o); end
    total++; if (an_o !== 4'b1110) begin bad++; $display("FAIL reset_an got=%b want=1110", an_o); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", in_ready); end
    total++; if (shown_valid !== 1'b0) begin bad++; $display("FAIL reset_shown got=%b want=0", shown_valid); end
    total++; if (flags_o !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b want=000", flags_o); end
    rst_n = 1'b1;
  endtask

  task automatic test_scan;
    logic [3:0] seq [5];
    int n;
    seq[0] = 4'b1101; seq[1] = 4'b1011; seq[2] = 4'b0111; seq[3] = 4'b1110; seq[4] = 4'b1101;
    n = 0;
    while (an_o !== 4'b1101 && n < 12) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (an_o !== 4'b1101) begin
      bad++; $display("FAIL scan_start got=%b want=1101", an_o);
    end else begin
      for (int k = 0; k < 4; k++) begin
        for (int j = 0; j < 4; j++) begin
          total++;
          if (an_o !== seq[k]) begin
            bad++; $display("FAIL scan_an step=%0d cyc=%0d got=%b want=%b", k, j, an_o, seq[k]);
          end
          @(negedge clk);
        end
      end
      total++;
      if (an_o !== seq[4]) begin bad++; $display("FAIL scan_wrap got=%b want=%b", an_o, seq[4]); end
    end
  endtask

  task automatic do_accept(input logic [3:0] res, input logic sgn, input logic o,
                           input logic c, input logic z, input exp_t e);
    @(negedge clk);
    in_res = res; in_signed = sgn; in_overflow = o; in_carry = c; in_zero = z;
    in_valid = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL acc_ready got=%b want=1", in_ready); end
    sb_q.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL load_ready got=%b want=0", in_ready); end
    total++; if (shown_valid !== 1'b1) begin bad++; $display("FAIL load_shown got=%b want=1", shown_valid); end
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL show_ready got=%b want=1", in_ready); end
  endtask

  task automatic check_display(input logic want_shown);
    exp_t e;
    logic [7:0] want;
    total++;
    if (sb_q.size() == 0) begin
      bad++; $display("FAIL sb_empty got=0 want=1 entries");
    end else begin
      e = sb_q.pop_front();
      total++; if (flags_o !== e.flags) begin bad++; $display("FAIL flags got=%b want=%b", flags_o, e.flags); end
      total++; if (shown_valid !== want_shown) begin bad++; $display("FAIL shown got=%b want=%b", shown_valid, want_shown); end
      for (int i = 0; i < 16; i++) begin
        @(negedge clk);
        case (an_o)
          4'b1110: want = e.segs[7:0];
          4'b1101: want = e.segs[15:8];
          4'b1011: want = e.segs[23:16];
          4'b0111: want = e.segs[31:24];
          default: want = 8'hxx;
        endcase
        total++;
        if (seg_o !== want) begin
          bad++; $display("FAIL digit an=%b got=%h want=%h", an_o, seg_o, want);
        end
      end
    end
  endtask

  task automatic test_hex;
    do_accept(4'hA, 1'b0, 1'b0, 1'b0, 1'b0, make_exp(8'h88, 8'hFF, 1'b0, 1'b0, 1'b0));
    check_display(1'b1);
  endtask

  task automatic test_signed;
    do_accept(4'b1000, 1'b1, 1'b0, 1'b0, 1'b0, make_exp(8'h80, 8'hBF, 1'b0, 1'b0, 1'b0));
    check_display(1'b1);
    do_accept(4'hF, 1'b1, 1'b0, 1'b0, 1'b0, make_exp(8'hF9, 8'hBF, 1'b0, 1'b0, 1'b0));
    check_display(1'b1);
    do_accept(4'h3, 1'b1, 1'b0, 1'b0, 1'b0, make_exp(8'hB0, 8'hFF, 1'b0, 1'b0, 1'b0));
    check_display(1'b1);
  endtask

  task automatic test_back_to_back;
    logic [7:0] gl [4];
    int acc;
    gl[0] = 8'hF9; gl[1] = 8'hA4; gl[2] = 8'hB0; gl[3] = 8'h99;
    acc = 0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      in_res = 4'(i + 1); in_signed = 1'b0; in_overflow = 1'b0; in_carry = 1'b0; in_zero = 1'b0;
      in_valid = 1'b1;
      #1;
      if (in_ready === 1'b1) begin
        acc++;
        sb_q.push_back(make_exp(gl[i], 8'hFF, 1'b0, 1'b0, 1'b0));
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    total++; if (acc != 2) begin bad++; $display("FAIL b2b_accepts got=%0d want=2", acc); end
    while (sb_q.size() > 1) void'(sb_q.pop_front());
    check_display(1'b1);
  endtask

  task automatic test_clear;
    @(negedge clk);
    clear = 1'b1; in_valid = 1'b1; in_res = 4'h5; in_carry = 1'b1;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL clear_ready got=%b want=0", in_ready); end
    @(negedge clk);
    clear = 1'b0; in_valid = 1'b0; in_carry = 1'b0;
    sb_q.push_back('{segs: 32'hFFFF_FFFF, flags: 3'b000});
    check_display(1'b0);
  endtask

  task automatic test_flags;
    do_accept(4'h0, 1'b0, 1'b1, 1'b1, 1'b1, make_exp(8'hC0, 8'hFF, 1'b1, 1'b1, 1'b1));
    check_display(1'b1);
  endtask

  initial begin
    test_reset();
    test_scan();
    test_hex();
    test_signed();
    test_back_to_back();
    test_clear();
    test_flags();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
